pe_seq_ctrl: RTL and testbench

//  Upstream sequencer for one PE.
//  - On i_start, clears the PE accumulator.
//  - Fetches an input/weight vector from a dual-word buffer and streams one

---
 rtl/pe_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_pe_seq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences one PE run: clear, stream buffered operand pairs, wait out activation latency, capture result.
module pe_seq_ctrl #(
  parameter int VEC_LEN = 16,
  parameter int ADDR_W  = 4,
  parameter int ACC_LAT = 1,
  parameter int SIG_LAT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ADDR_W:0]      i_len,
  input  logic                 i_op_activation,
  input  logic                 i_no_rect_quantize,
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_rd_addr,
  input  logic signed [7:0]    i_rd_data,
  input  logic signed [7:0]    i_rd_weight,
  output logic signed [7:0]    o_pe_data,
  output logic signed [7:0]    o_pe_weight,
  output logic                 o_pe_acc_clr,
  output logic                 o_pe_op_activation,
  output logic                 o_pe_no_rect_quantize,
  input  logic [7:0]           i_pe_data,
  input  logic                 i_pe_decision,
  output logic                 o_busy,
  output logic [7:0]           o_result,
  output logic                 o_decision,
  output logic                 o_result_valid
);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, WAIT, DONE} state_t;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(VEC_LEN);
  localparam logic [7:0] ACC_W = 8'(ACC_LAT - 1);
  localparam logic [7:0] SIG_W = 8'(SIG_LAT);
  state_t state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] tmr_q, tmr_d, wait_len;
  logic act_q, act_d, nrq_q, nrq_d;
  logic rd_en_q, rd_v_q, acc_clr_q, busy_q, dec_q, valid_q;
  logic signed [7:0] pe_data_q, pe_weight_q;
  logic [7:0] result_q;
  // Sigmoid pipeline only applies when the activated (quantized) output is used
  assign wait_len = ACC_W + ((act_q & ~nrq_q) ? SIG_W : 8'd0);
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    addr_d = addr_q;
    tmr_d = tmr_q;
    act_d = act_q;
    nrq_d = nrq_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = CLEAR;
        len_d = (i_len > MAX_LEN) ? MAX_LEN : i_len;
        act_d = i_op_activation;
        nrq_d = i_no_rect_quantize;
      end
      CLEAR: begin
        state_d = (len_q == '0) ? DRAIN : STREAM;
        addr_d = '0;
        tmr_d = 8'd1;
      end
      STREAM: if ({1'b0, addr_q} == len_q - 1'b1) begin
        state_d = DRAIN;
        tmr_d = 8'd1;
      end else addr_d = addr_q + 1'b1;
      DRAIN: if (tmr_q == '0) begin
        state_d = (wait_len == '0) ? DONE : WAIT;
        tmr_d = wait_len - 8'd1;
      end else tmr_d = tmr_q - 8'd1;
      WAIT: if (tmr_q == '0) state_d = DONE;
            else tmr_d = tmr_q - 8'd1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      len_q <= '0;
      addr_q <= '0;
      tmr_q <= '0;
      act_q <= 1'b0;
      nrq_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_v_q <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q <= 1'b0;
      pe_data_q <= '0;
      pe_weight_q <= '0;
      result_q <= '0;
      dec_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      addr_q <= addr_d;
      tmr_q <= tmr_d;
      act_q <= act_d;
      nrq_q <= nrq_d;
      rd_en_q <= state_d == STREAM;
      rd_v_q <= rd_en_q;
      acc_clr_q <= state_d == CLEAR;
      busy_q <= state_d != IDLE;
      pe_data_q <= rd_v_q ? i_rd_data : 8'sd0;
      pe_weight_q <= rd_v_q ? i_rd_weight : 8'sd0;
      result_q <= (state_q == DONE) ? i_pe_data : result_q;
      dec_q <= (state_q == DONE) ? i_pe_decision : dec_q;
      valid_q <= state_q == DONE;
    end
  end
  assign o_rd_en = rd_en_q;
  assign o_rd_addr = addr_q;
  assign o_pe_data = pe_data_q;
  assign o_pe_weight = pe_weight_q;
  assign o_pe_acc_clr = acc_clr_q;
  assign o_pe_op_activation = act_q;
  assign o_pe_no_rect_quantize = nrq_q;
  assign o_busy = busy_q;
  assign o_result = result_q;
  assign o_decision = dec_q;
  assign o_result_valid = valid_q;
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed bench with a buffer + PE model and a result scoreboard for pe_seq_ctrl.
module tb_pe_seq_ctrl;
  logic clk = 1'b0, i_rst, i_start, i_op, i_nrq;
  logic [4:0] i_len;
  logic o_rd_en, o_pe_acc_clr, o_pe_op_activation, o_pe_no_rect_quantize;
  logic o_busy, o_decision, o_result_valid, pe_dec;
  logic [3:0] o_rd_addr;
  logic signed [7:0] rd_data, rd_weight, o_pe_data, o_pe_weight;
  logic [7:0] o_result, pe_out;
  logic signed [7:0] dmem [16];
  logic signed [7:0] wmem [16];
  logic signed [15:0] acc, pe_src;
  logic [3:0][15:0] sp;
  int cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct {logic [7:0] res; logic dec; int cyc;} exp_t;
  exp_t exp_q[$];

  pe_seq_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_op_activation(i_op), .i_no_rect_quantize(i_nrq),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(rd_data), .i_rd_weight(rd_weight),
    .o_pe_data(o_pe_data), .o_pe_weight(o_pe_weight), .o_pe_acc_clr(o_pe_acc_clr),
    .o_pe_op_activation(o_pe_op_activation), .o_pe_no_rect_quantize(o_pe_no_rect_quantize),
    .i_pe_data(pe_out), .i_pe_decision(pe_dec), .o_busy(o_busy), .o_result(o_result),
    .o_decision(o_decision), .o_result_valid(o_result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read buffer and PE (acc += d*w; sigmoid path = acc delayed 4)
  always @(posedge clk) begin
    if (o_rd_en) begin
      rd_data <= dmem[o_rd_addr];
      rd_weight <= wmem[o_rd_addr];
    end
    if (i_rst || o_pe_acc_clr) acc <= '0;
    else acc <= acc + o_pe_data * o_pe_weight;
    sp <= {sp[2:0], acc};
  end
  assign pe_src = (o_pe_op_activation && !o_pe_no_rect_quantize) ? $signed(sp[3]) : acc;
  assign pe_out = o_pe_no_rect_quantize ? acc[7:0] : (pe_src < 0 ? 8'd0 : pe_src[7:0]);
  assign pe_dec = |pe_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (o_result_valid) begin
      chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", o_result, e.res);
        chk("decision", o_decision, e.dec);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Starts a run in the current cycle and checks it cycle by cycle until its valid cycle
  task automatic run(input int len, input bit act, input bit nrq, input bit poke);
    int l, last;
    logic signed [15:0] a;
    exp_t e;
    l = len > 16 ? 16 : len;
    a = '0;
    for (int k = 0; k < l; k++) a += dmem[k] * wmem[k];
    last = l + ((act && !nrq) ? 9 : 5);
    e.res = nrq ? a[7:0] : (a < 0 ? 8'd0 : a[7:0]);
    e.dec = |e.res;
    e.cyc = cyc + last;
    exp_q.push_back(e);
    i_len = 5'(len);
    i_op = act;
    i_nrq = nrq;
    i_start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      step();
      i_start = poke && c == 3;
      if (poke && c == 3) begin
        i_op = ~act;
        i_nrq = ~nrq;
      end
      @(negedge clk);
      chk("acc_clr", o_pe_acc_clr, 64'(c == 1));
      chk("rd_en", o_rd_en, 64'(c >= 2 && c < l + 2));
      if (c >= 2 && c < l + 2) chk("rd_addr", o_rd_addr, 64'(c - 2));
      chk("pe_ops", {o_pe_data, o_pe_weight}, (c >= 4 && c < l + 4) ? {dmem[c-4], wmem[c-4]} : 16'h0);
      chk("busy", o_busy, 64'(c < last));
      chk("mode", {o_pe_op_activation, o_pe_no_rect_quantize}, {act, nrq});
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_op = 1'b0; i_nrq = 1'b0; i_len = '0;
    for (int k = 0; k < 16; k++) begin dmem[k] = '0; wmem[k] = '0; end
    step();
    step();
    @(negedge clk);
    chk("reset_outputs", {o_rd_en, o_rd_addr, o_pe_data, o_pe_weight, o_pe_acc_clr, o_pe_op_activation,
        o_pe_no_rect_quantize, o_busy, o_result, o_decision, o_result_valid}, 64'd0);
    step();
    i_rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin dmem[k] = 8'(k + 1); wmem[k] = 8'sd1; end
    run(4, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    @(negedge clk);
    chk("result_hold", {o_result, o_result_valid}, {8'd10, 1'b0});
    step();
    run(4, 1'b1, 1'b0, 1'b0);
    step();
    run(0, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 16; k++) begin dmem[k] = 8'(k + 1); wmem[k] = 8'sd1; end
    run(20, 1'b0, 1'b0, 1'b0);
    step();
    dmem[0] = -8'sd3; dmem[1] = 8'sd5; wmem[0] = 8'sd4; wmem[1] = -8'sd2;
    run(2, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 8; k++) begin dmem[k] = 8'sd2; wmem[k] = 8'sd3; end
    i_len = 5'd8; i_op = 1'b0; i_nrq = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (4) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset", {o_rd_en, o_rd_addr, o_pe_data, o_pe_weight, o_pe_acc_clr, o_pe_op_activation,
        o_pe_no_rect_quantize, o_busy, o_result, o_decision, o_result_valid}, 64'd0);
    repeat (15) step();
    @(negedge clk);
    chk("idle_after_reset", o_busy, 64'd0);
    step();
    dmem[0] = -8'sd3; dmem[1] = 8'sd5; wmem[0] = 8'sd4; wmem[1] = -8'sd2;
    run(2, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
